address_decoder_seq: RTL

Sequential chip-select generator for the 15-slot address space. It takes a 4-bit slot address from the controller and drives the registered one-hot select vector that the address encoder consumes. It holds the select until the addressed slave acknowledges or a timeout expires, then returns a one-cycle response with status. Round trip: 4-bit address -> one-hot select -> the encoder's 4-bit code must equal the original address.

---
 rtl/address_decoder_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/address_decoder_seq.sv
// Sequential chip-select generator: one registered one-hot select per accepted slot address,
// held until the selected slave acks or the wait counter expires, then a one-cycle response.
module address_decoder_seq #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  req_addr,
    output logic        req_ready,
    output logic [14:0] sel,
    input  logic [14:0] slv_ack,
    output logic        resp_valid,
    output logic [1:0]  resp_code,
    output logic [3:0]  resp_addr,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam logic [1:0] CodeOk      = 2'b00;
    localparam logic [1:0] CodeDecErr  = 2'b01;
    localparam logic [1:0] CodeTimeout = 2'b10;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [3:0]       addr_q, addr_d;
    logic [14:0]      sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic             ack_hit;

    // Slot 0 sits on the top select bit so the encoder's priority code maps back to 0.
    function automatic logic [14:0] decode(input logic [3:0] a);
        logic [14:0] oh;
        case (a)
            4'h0:    oh = 15'h4000;
            4'hF:    oh = '0;
            default: oh = 15'(1) << (a - 4'd1);
        endcase
        return oh;
    endfunction

    // Only the ack bit matching the live select counts.
    assign ack_hit = |(slv_ack & sel_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        code_d  = code_q;

        case (state_q)
            StIdle: begin
                sel_d = '0;
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = '0;
                    if (req_addr == 4'hF) begin
                        state_d = StResp;
                        code_d  = CodeDecErr;
                    end else begin
                        state_d = StWait;
                        sel_d   = decode(req_addr);
                    end
                end
            end
            StWait: begin
                if (ack_hit) begin
                    state_d = StResp;
                    code_d  = CodeOk;
                    sel_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StResp;
                    code_d  = CodeTimeout;
                    sel_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
                sel_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            code_q  <= CodeOk;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign resp_valid = (state_q == StResp);
    assign sel        = sel_q;
    assign resp_code  = code_q;
    assign resp_addr  = addr_q;

endmodule
